// File: rtl/uart_pkg.sv
// uart_pkg: shared transmitter state type and standard baud divisors for the 50 MHz UART subsystem
package uart_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} tx_state_t;
  localparam int CLKDIV_115200 = 434;
  localparam int CLKDIV_9600 = 5208;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with occupancy count, shared by the UART transmit and receive paths
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] count_q;
  logic do_push, do_pop;
  assign do_push = push_i & ~full_o;
  assign do_pop = pop_i & ~empty_o;
  assign full_o = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign dout_o = mem_q[rd_q];
  assign count_o = count_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end
  // storage needs no reset: entries are only read after being written
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter sending back-to-back 8N1 or 8E1/8O1 frames
module uart_tx_fifo import uart_pkg::*; #(
  parameter int CLKDIV = CLKDIV_115200,
  parameter int DEPTH = 8,
  parameter int PARITY_EN = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                     clk_50M,
  input  logic                     rst,
  input  logic [7:0]               din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);
  localparam logic [12:0] BAUD_MAX = 13'(CLKDIV - 1);
  tx_state_t state_q;
  logic [12:0] baud_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q, head;
  logic par_q, tx_q, full, empty, last, pop;
  assign last = baud_q == BAUD_MAX;
  // a pop always starts a new frame, either from idle or at the end of a stop bit
  assign pop = ~empty & (state_q == ST_IDLE | (state_q == ST_STOP & last));
  assign din_ready = ~full;
  assign tx = tx_q;
  assign busy = (state_q != ST_IDLE) | ~empty;
  uart_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk_i  (clk_50M),
    .rst_i  (rst),
    .push_i (din_valid),
    .din_i  (din),
    .pop_i  (pop),
    .dout_o (head),
    .full_o (full),
    .empty_o(empty),
    .count_o(count)
  );
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      tx_q <= 1'b1;
    end else begin
      baud_q <= (state_q == ST_IDLE || last) ? '0 : baud_q + 13'd1;
      if (pop) begin
        state_q <= ST_START;
        tx_q <= 1'b0;
        shift_q <= head;
        bit_q <= '0;
        par_q <= ^head ^ (PARITY_ODD != 0);
      end else if (last) begin
        case (state_q)
          ST_START: begin
            state_q <= ST_DATA;
            tx_q <= shift_q[0];
          end
          ST_DATA: begin
            shift_q <= shift_q >> 1;
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_q <= PARITY_EN != 0 ? ST_PARITY : ST_STOP;
              tx_q <= PARITY_EN != 0 ? par_q : 1'b1;
            end else tx_q <= shift_q[1];
          end
          ST_PARITY: begin
            state_q <= ST_STOP;
            tx_q <= 1'b1;
          end
          ST_STOP: begin
            state_q <= ST_IDLE;
            tx_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter for the 50 MHz UART subsystem. It accepts bytes from on-chip logic over a valid/ready handshake into an internal FIFO. It serialises them onto the `tx` line as 8N1 frames, or 8E1/8O1 frames when parity is enabled, back-to-back without idle gaps. It is the host-to-line counterpart of the UART receive path and replaces direct single-byte loading for bursty producers.

## Interface
- `CLKDIV`, 434: clock cycles per bit (434 = 115200 baud at 50 MHz; 5208 = 9600). Legal range is 2 to 8191.
- `DEPTH`, 8: FIFO entries. Must be a power of two, at least 2.
- `PARITY_EN`, 0: 1 inserts a parity bit between data bit 7 and the stop bit.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd parity. Ignored when `PARITY_EN`=0.
- `clk_50M`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `din`  in  8  byte to send.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  FIFO not full.
- `tx`  out  1  serial line, registered, idle high.
- `busy`  out  1  FIFO non-empty or frame in progress.
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Push: occurs on the rising edge where `din_valid & din_ready` is true. `din_valid` with `din_ready`=0 is ignored and the byte is not stored. `din` needs to be stable only in the accepting cycle.
- `din_ready` = (`count` != `DEPTH`), combinational from `count`.
- Frame format: start bit (0), then `din[0]` through `din[7]` (LSB first), then the optional parity bit, then one stop bit (1).
  - Even parity bit = XOR of the data bits.
  - Odd parity bit = its inverse.
- State machine: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when FIFO non-empty. The head byte is popped into the shift register on the same edge.
  - START → DATA after `CLKDIV` cycles.
  - DATA → PARITY (if `PARITY_EN`) or STOP after 8 bit periods. The bit index is a 3-bit counter, 0 to 7.
  - PARITY → STOP after one bit period.
  - STOP → START, with a pop on the same edge, if the FIFO is non-empty; otherwise STOP → IDLE. Both happen after one bit period.
- Baud counter: counts 0 to `CLKDIV`-1 in every non-IDLE state and wraps to 0 at each bit boundary. It is held at 0 in IDLE.
- `tx` register values by state:
  - IDLE and STOP: 1.
  - START: 0.
  - DATA: current shift-register LSB.
  - PARITY: the computed parity bit.
- Parity is computed at pop time from the popped byte.
- `busy` = (state != IDLE) | (`count` != 0).
- Simultaneous push and pop: `count` is unchanged and both take effect. A push into a full FIFO cannot occur because ready is low. Pop from an empty FIFO cannot occur.
- FIFO pointers are $clog2(DEPTH) bits and wrap naturally modulo `DEPTH`. `count` is a separate counter.

## Timing
- Reset values: `tx`=1, `din_ready`=1, `busy`=0, `count`=0, state=IDLE, FIFO pointers 0.
- Reset is asynchronous. If asserted mid-frame, `tx` returns to 1 immediately, the frame is truncated and all buffered bytes are discarded. Operation resumes on the first edge after deassertion.
- Latency when idle and empty:
  - Byte accepted at edge E0.
  - State enters START and `tx` falls at edge E1.
  - `busy` rises after E0.
- Each bit lasts exactly `CLKDIV` cycles.
- Frame length is 10×`CLKDIV` cycles, or 11×`CLKDIV` cycles with parity.
- Consecutive buffered bytes produce contiguous frames: the next start bit begins on the edge that ends the previous stop bit.
- `busy` falls on the edge where STOP → IDLE.

## Structure
- Shared package `uart_pkg`:
  - state enum `tx_state_t`;
  - constants `CLKDIV_115200`=434 and `CLKDIV_9600`=5208, for reuse by the receive side.
- Sub-module `uart_sync_fifo` (parameters: `WIDTH`, `DEPTH`) with push, pop, `dout`, full, empty and `count`. It is also intended for a future buffered receiver.
- Top level: the FSM, baud counter, bit counter, shift register and parity logic.

## Test plan
- `CLKDIV`=4, push 0x55 when idle: `tx` falls 1 cycle later, then reads 0,1,0,1,0,1,0,1,0,1 with 4 cycles per bit, then idles high. `busy` is high for 41 cycles.
- Push 0xA3, 0x00, 0xFF back-to-back: three contiguous frames totalling 120 cycles at `CLKDIV`=4, with no high gap between stop and start. Decoded bytes are 0xA3, 0x00, 0xFF in that order.
- `DEPTH`=8, hold `din_valid` high for 12 cycles from idle: exactly 9 bytes accepted (the first pops on E1), `din_ready` low with `count`=8. Ready returns high when the second byte is popped.
- `PARITY_EN`=1, push 0x07:
  - even parity: parity bit 1, 11-bit frame;
  - `PARITY_ODD`=1: parity bit 0.
- Assert `rst` during data bit 3 with 4 bytes queued: `tx`=1 and `count`=0 immediately. After release, no further frames appear, and a new push of 0x3C transmits correctly.
- Push and pop on the same edge with `count`=5: `count` stays 5, and FIFO order is preserved across pointer wrap-around after 20 bytes.
